// File: rtl/noise_src.sv
// noise_src: pseudo-random noise bit source for the display pattern generator.
// Two maximal-length LFSRs (32-bit A, 31-bit B) are XOR-combined into an 8-bit
// word. The word is compared against a density threshold to give one noise bit
// per enabled pixel clock. A windowed ones-count reports the output bias.
module noise_src #(
  parameter logic [31:0] SEED_A   = 32'hACE1_2468,
  parameter logic [30:0] SEED_B   = 31'h1357_9BDF,
  parameter int unsigned WIN_LOG2 = 16
) (
  input  logic                pix_clk,
  input  logic                reset,
  input  logic                en,
  input  logic                frame_start,
  input  logic                reseed_on_frame,
  input  logic                seed_load,
  input  logic [31:0]         seed_in,
  input  logic [7:0]          density,
  output logic                rnd,
  output logic                rnd_valid,
  output logic [31:0]         state_a,
  output logic [WIN_LOG2:0]   bias_meas,
  output logic                bias_valid
);

  localparam logic [WIN_LOG2-1:0] WIN_LAST = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};

  // x^32 + x^22 + x^2 + x + 1, Fibonacci form
  function automatic logic [31:0] lfsr_a_step(input logic [31:0] a);
    return {a[30:0], a[31] ^ a[21] ^ a[1] ^ a[0]};
  endfunction

  // x^31 + x^28 + 1, Fibonacci form
  function automatic logic [30:0] lfsr_b_step(input logic [30:0] b);
    return {b[29:0], b[30] ^ b[27]};
  endfunction

  logic [31:0]         a_q, a_d;
  logic [30:0]         b_q, b_d;
  logic                rnd_q, rnd_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_LOG2:0]   acc_q, acc_d;
  logic [WIN_LOG2:0]   bias_meas_q, bias_meas_d;
  logic                bias_valid_q, bias_valid_d;

  logic [7:0]          word_s;
  logic [30:0]         seed_mix_s;
  logic [WIN_LOG2:0]   rnd_ext_s;

  assign word_s     = a_q[7:0] ^ b_q[7:0];
  assign seed_mix_s = seed_in[30:0] ^ SEED_B;
  assign rnd_ext_s  = {{WIN_LOG2{1'b0}}, rnd_q};

  // Output bit: computed from the pre-update LFSR state whenever en is high,
  // so loads and reseeds never leave a gap in the stream.
  always_comb begin
    rnd_d       = rnd_q;
    rnd_valid_d = 1'b0;
    if (en) begin
      rnd_d       = (word_s < density);
      rnd_valid_d = 1'b1;
    end else begin
      rnd_d       = rnd_q;
      rnd_valid_d = 1'b0;
    end
  end

  // LFSR next state: seed_load beats frame reseed beats a normal step.
  // Zero loads are replaced by the seed parameter so neither LFSR can lock up.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (seed_load) begin
      a_d = (seed_in == 32'd0) ? SEED_A : seed_in;
      b_d = (seed_mix_s == 31'd0) ? SEED_B : seed_mix_s;
    end else if (frame_start && reseed_on_frame) begin
      a_d = SEED_A;
      b_d = SEED_B;
    end else if (en) begin
      a_d = lfsr_a_step(a_q);
      b_d = lfsr_b_step(b_q);
    end else begin
      a_d = a_q;
      b_d = b_q;
    end
  end

  // Bias window: count valid output cycles, accumulate ones, publish on the last.
  always_comb begin
    win_cnt_d    = win_cnt_q;
    acc_d        = acc_q;
    bias_meas_d  = bias_meas_q;
    bias_valid_d = 1'b0;
    if (rnd_valid_q) begin
      if (win_cnt_q == WIN_LAST) begin
        bias_meas_d  = acc_q + rnd_ext_s;
        bias_valid_d = 1'b1;
        win_cnt_d    = {WIN_LOG2{1'b0}};
        acc_d        = {(WIN_LOG2+1){1'b0}};
      end else begin
        win_cnt_d    = win_cnt_q + WIN_ONE;
        acc_d        = acc_q + rnd_ext_s;
        bias_meas_d  = bias_meas_q;
        bias_valid_d = 1'b0;
      end
    end else begin
      win_cnt_d    = win_cnt_q;
      acc_d        = acc_q;
      bias_meas_d  = bias_meas_q;
      bias_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      a_q          <= SEED_A;
      b_q          <= SEED_B;
      rnd_q        <= 1'b0;
      rnd_valid_q  <= 1'b0;
      win_cnt_q    <= {WIN_LOG2{1'b0}};
      acc_q        <= {(WIN_LOG2+1){1'b0}};
      bias_meas_q  <= {(WIN_LOG2+1){1'b0}};
      bias_valid_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      rnd_q        <= rnd_d;
      rnd_valid_q  <= rnd_valid_d;
      win_cnt_q    <= win_cnt_d;
      acc_q        <= acc_d;
      bias_meas_q  <= bias_meas_d;
      bias_valid_q <= bias_valid_d;
    end
  end

  assign rnd        = rnd_q;
  assign rnd_valid  = rnd_valid_q;
  assign state_a    = a_q;
  assign bias_meas  = bias_meas_q;
  assign bias_valid = bias_valid_q;

endmodule

// File: tb/tb_noise_src.sv
// tb_noise_src: directed stimulus for noise_src with a behavioural model that
// is compared against every output on every cycle after reset, plus literal
// expectations that pin the model. The bias window is shortened to 2^10.
module tb_noise_src;

  localparam int W = 10;
  localparam int N = 1 << W;
  localparam logic [31:0] SA = 32'hACE1_2468;
  localparam logic [30:0] SB = 31'h1357_9BDF;

  logic        pix_clk = 1'b0;
  logic        reset, en, frame_start, reseed_on_frame, seed_load;
  logic [31:0] seed_in;
  logic [7:0]  density;
  logic        rnd, rnd_valid, bias_valid;
  logic [31:0] state_a;
  logic [W:0]  bias_meas;

  noise_src #(.SEED_A(SA), .SEED_B(SB), .WIN_LOG2(W)) dut (
    .pix_clk(pix_clk), .reset(reset), .en(en), .frame_start(frame_start),
    .reseed_on_frame(reseed_on_frame), .seed_load(seed_load), .seed_in(seed_in),
    .density(density), .rnd(rnd), .rnd_valid(rnd_valid), .state_a(state_a),
    .bias_meas(bias_meas), .bias_valid(bias_valid)
  );

  always #5 pix_clk = ~pix_clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_a;
  logic [30:0] m_b;
  logic        m_rnd, m_valid, m_bv;
  logic [W:0]  m_bias;
  int          m_cnt, m_ones;

  // Polynomial step expressed via tap masks: feedback is parity of tapped bits.
  function automatic logic [31:0] nxt_a(input logic [31:0] x);
    return (x << 1) | {31'd0, ^(x & 32'h8020_0003)};
  endfunction
  function automatic logic [30:0] nxt_b(input logic [30:0] x);
    return (x << 1) | {30'd0, ^(x & 31'h4800_0000)};
  endfunction

  task automatic model_step();
    logic [7:0]  w;
    logic [30:0] mix;
    if (reset) begin
      m_a = SA; m_b = SB; m_rnd = 1'b0; m_valid = 1'b0; m_bv = 1'b0;
      m_bias = '0; m_cnt = 0; m_ones = 0;
    end else begin
      m_bv = 1'b0;
      if (m_valid) begin
        m_cnt  = m_cnt + 1;
        m_ones = m_ones + int'(m_rnd);
        if (m_cnt == N) begin
          m_bias = m_ones[W:0]; m_bv = 1'b1; m_cnt = 0; m_ones = 0;
        end
      end
      w = m_a[7:0] ^ m_b[7:0];
      if (en) m_rnd = (int'(w) < int'(density));
      m_valid = en;
      if (seed_load) begin
        mix = seed_in[30:0] ^ SB;
        m_a = (seed_in == 32'd0) ? SA : seed_in;
        m_b = (mix == 31'd0) ? SB : mix;
      end else if (frame_start && reseed_on_frame) begin
        m_a = SA; m_b = SB;
      end else if (en) begin
        m_a = nxt_a(m_a); m_b = nxt_b(m_b);
      end
    end
  endtask

  always @(posedge pix_clk) model_step();

  // Per-cycle compare of all outputs against the model.
  always @(negedge pix_clk) begin
    if (chk_on) begin
      chk("rnd", rnd, m_rnd);
      chk("rnd_valid", rnd_valid, m_valid);
      chk("state_a", state_a, m_a);
      chk("bias_meas", bias_meas, m_bias);
      chk("bias_valid", bias_valid, m_bv);
    end
  end

  task automatic cyc();
    @(negedge pix_clk);
    cyc_n++;
  endtask

  logic        seq [3][1000];
  logic [31:0] prev_a;
  int          vcount, last_bv, nbv, diff;
  bit          found;

  initial begin
    reset = 1'b1; en = 1'b0; frame_start = 1'b0; reseed_on_frame = 1'b0;
    seed_load = 1'b0; seed_in = 32'd0; density = 8'd0;
    repeat (3) cyc();
    chk_on = 1'b1;
    reset  = 1'b0;
    chk("reset_state_a", state_a, 32'hACE1_2468);
    chk("reset_rnd", rnd, 1'b0);
    chk("reset_rnd_valid", rnd_valid, 1'b0);
    chk("reset_bias", {bias_valid, bias_meas}, '0);

    // First word after reset is 0x68 ^ 0xDF = 0xB7.
    density = 8'hB8; en = 1'b1; cyc(); en = 1'b0;
    chk("step1_state_a", state_a, 32'h59C2_48D0);
    chk("step1_rnd_b8", rnd, 1'b1);
    chk("step1_valid", rnd_valid, 1'b1);
    cyc();
    chk("hold_valid", rnd_valid, 1'b0);
    chk("hold_state_a", state_a, 32'h59C2_48D0);
    chk("hold_rnd", rnd, 1'b1);
    en = 1'b1; cyc(); en = 1'b0;
    chk("step2_state_a", state_a, 32'hB384_91A0);
    reset = 1'b1; cyc(); reset = 1'b0;
    density = 8'hB7; en = 1'b1; cyc();
    chk("step1_rnd_b7", rnd, 1'b0);

    // density = 0: all zeros, first window reports 0 after N valid outputs.
    reset = 1'b1; en = 1'b0; cyc(); reset = 1'b0;
    density = 8'd0; en = 1'b1; vcount = 0; found = 1'b0; last_bv = 0;
    repeat (N + 50) begin
      cyc();
      chk("zero_density_rnd", rnd, 1'b0);
      if (bias_valid && !found) begin
        found = 1'b1;
        chk("bias0_meas", bias_meas, '0);
        chk("bias0_valid_count", vcount, N);
        last_bv = cyc_n;
      end
      if (rnd_valid) vcount++;
    end
    chk("bias0_seen", found, 1'b1);

    // density = 128: windows near half full, exactly N cycles apart.
    density = 8'd128; nbv = 0;
    repeat (2 * N + 50) begin
      cyc();
      if (bias_valid) begin
        nbv++;
        chk("bias_period", cyc_n - last_bv, N);
        chk("bias_range", (int'(bias_meas) >= N/2 - 96) && (int'(bias_meas) <= N/2 + 96), 1'b1);
        last_bv = cyc_n;
      end
    end
    chk("bias_pulses", nbv >= 2, 1'b1);

    // Software seeds, including both zero-guard cases.
    seed_load = 1'b1; seed_in = 32'd0; cyc(); seed_load = 1'b0;
    chk("seed_zero", state_a, 32'hACE1_2468);
    seed_load = 1'b1; seed_in = 32'h1234_5678; cyc(); seed_load = 1'b0;
    chk("seed_12345678", state_a, 32'h1234_5678);
    repeat (200) cyc();
    seed_load = 1'b1; seed_in = 32'h1357_9BDF; cyc(); seed_load = 1'b0;
    chk("seed_b_guard", state_a, 32'h1357_9BDF);
    repeat (50) cyc();

    // Frame reseed: identical frames when enabled.
    reseed_on_frame = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 1000; i++) begin
        frame_start = (i == 0); cyc(); seq[f][i] = rnd;
      end
    end
    frame_start = 1'b0;
    for (int f = 1; f < 3; f++) begin
      diff = 0;
      for (int i = 1; i < 1000; i++) if (seq[f][i] !== seq[0][i]) diff++;
      chk("frame_repeat", diff, 0);
    end
    reseed_on_frame = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 1000; i++) begin
        frame_start = (i == 0); cyc(); seq[f][i] = rnd;
      end
    end
    frame_start = 1'b0;
    diff = 0;
    for (int i = 1; i < 1000; i++) if (seq[1][i] !== seq[0][i]) diff++;
    chk("frame_differ", diff != 0, 1'b1);

    // Alternating enable.
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0); prev_a = state_a; cyc();
      chk("toggle_valid", rnd_valid, en);
      if (!en) chk("toggle_hold", state_a, prev_a);
    end

    // seed_load wins over a simultaneous frame reseed.
    en = 1'b1; reseed_on_frame = 1'b1; frame_start = 1'b1; seed_load = 1'b1;
    seed_in = 32'h0BAD_F00D; cyc();
    frame_start = 1'b0; seed_load = 1'b0;
    chk("seed_beats_frame", state_a, 32'h0BAD_F00D);
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    chk("frame_reload", state_a, 32'hACE1_2468);
    repeat (20) cyc();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
